// File: rtl/lfsr_prbs_check.sv
// lfsr_prbs_check: self-synchronising PRBS checker with a lock FSM
// and saturating bit/word error counters.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   data_in[_valid]   received word, no backpressure
//   err_clear         clears both counters and lock_lost
//   err_out[_valid]   per-bit error flags, data_in bit order
//   locked, lock_lost lock state and sticky loss flag
//   bit/word_err_cnt  saturating error counts while locked
module lfsr_prbs_check #(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
  parameter bit LFSR_INVERT = 1'b1,
  parameter bit REVERSE = 1'b0,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] err_out,
  output logic                  err_out_valid,
  output logic                  locked,
  output logic                  lock_lost,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt,
  output logic [CNT_WIDTH-1:0]  word_err_cnt
);

  localparam int FILL_WORDS =
    (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FW = $clog2(FILL_WORDS + 1);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int PW = $clog2(DATA_WIDTH + 1);
  localparam int SW = (CNT_WIDTH > PW ? CNT_WIDTH : PW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [RW-1:0]         run_q, run_d;
  logic [LW-1:0]         loss_q, loss_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] data_t, err_t, err_w;
  logic [PW-1:0]         pop;
  logic [SW-1:0]         bit_add;
  logic                  word_err, checked, lost;

  // data_t/err_t are in arrival order: bit 0 is the earliest
  if (REVERSE) begin : g_rev
    assign data_t = data_in;
    assign err_w  = err_t;
  end else begin : g_fwd
    assign data_t = {<<{data_in}};
    assign err_w  = {<<{err_t}};
  end

  // lfsr[j] holds the bit received LFSR_WIDTH-j bits ago;
  // the register is fed from received bits only
  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    s = lfsr_q;
    err_t = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      err_t[k] = data_t[k] ^ (^(s & LFSR_POLY))
               ^ LFSR_INVERT;
      s = {data_t[k], s[LFSR_WIDTH-1:1]};
    end
    lfsr_d = s;
  end

  function automatic logic [PW-1:0] popcount(
    input logic [DATA_WIDTH-1:0] v
  );
    logic [PW-1:0] acc [DATA_WIDTH];
    for (int i = 0; i < DATA_WIDTH; i++)
      acc[i] = PW'(v[i]);
    for (int st = 1; st < DATA_WIDTH; st = st * 2)
      for (int i = 0; i + st < DATA_WIDTH; i = i + 2 * st)
        acc[i] = acc[i] + acc[i+st];
    return acc[0];
  endfunction

  assign pop      = popcount(err_t);
  assign word_err = |err_t;
  assign bit_add  = SW'(bit_err_cnt) + SW'(pop);
  assign locked   = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    loss_d  = loss_q;
    checked = 1'b0;
    lost    = 1'b0;
    if (data_in_valid) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(FILL_WORDS - 1)) begin
            state_d = HUNT;
            fill_d  = '0;
            run_d   = '0;
          end
        end
        HUNT: begin
          checked = 1'b1;
          if (word_err) begin
            run_d = '0;
          end else if (run_q == RW'(LOCK_COUNT - 1)) begin
            state_d = LOCKED;
            loss_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        LOCKED: begin
          checked = 1'b1;
          if (!word_err) begin
            loss_d = '0;
          end else if (loss_q == LW'(LOSS_COUNT - 1)) begin
            state_d = HUNT;
            run_d   = '0;
            lost    = 1'b1;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      fill_q        <= '0;
      run_q         <= '0;
      loss_q        <= '0;
      lfsr_q        <= '0;
      err_out       <= '0;
      err_out_valid <= 1'b0;
      lock_lost     <= 1'b0;
      bit_err_cnt   <= '0;
      word_err_cnt  <= '0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      run_q         <= run_d;
      loss_q        <= loss_d;
      err_out_valid <= checked;
      if (data_in_valid)
        lfsr_q <= lfsr_d;
      if (checked)
        err_out <= err_w;
      if (err_clear) begin
        lock_lost    <= 1'b0;
        bit_err_cnt  <= '0;
        word_err_cnt <= '0;
      end else begin
        if (lost)
          lock_lost <= 1'b1;
        if (checked && state_q == LOCKED) begin
          bit_err_cnt <= (bit_add > SW'(CNT_MAX)) ?
            CNT_MAX : bit_add[CNT_WIDTH-1:0];
          if (word_err && word_err_cnt != CNT_MAX)
            word_err_cnt <= word_err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
